alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_mul_seq.sv | 61 ++++++
 rtl/alu_seq_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control codes, aluop/funct encodings and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_or    = 2'b11;

    localparam logic [5:0] c_funct_add   = 6'b100000;
    localparam logic [5:0] c_funct_sub   = 6'b100010;
    localparam logic [5:0] c_funct_and   = 6'b100100;
    localparam logic [5:0] c_funct_or    = 6'b100101;
    localparam logic [5:0] c_funct_xor   = 6'b100110;
    localparam logic [5:0] c_funct_nor   = 6'b100111;
    localparam logic [5:0] c_funct_slt   = 6'b101010;
    localparam logic [5:0] c_funct_sltu  = 6'b101011;
    localparam logic [5:0] c_funct_multu = 6'b011001;

    localparam logic [3:0] c_alu_and     = 4'b0000;
    localparam logic [3:0] c_alu_or      = 4'b0001;
    localparam logic [3:0] c_alu_add     = 4'b0010;
    localparam logic [3:0] c_alu_xor     = 4'b0011;
    localparam logic [3:0] c_alu_nor     = 4'b0100;
    localparam logic [3:0] c_alu_sltu    = 4'b0101;
    localparam logic [3:0] c_alu_sub     = 4'b0110;
    localparam logic [3:0] c_alu_slt     = 4'b0111;
    localparam logic [3:0] c_alu_multu   = 4'b1100;
    localparam logic [3:0] c_alu_illegal = 4'b1111;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_mul  = 2'd1,
        st_done = 2'd2
    } ctrl_state_t;

    function automatic logic [3:0] alu_decode(input logic [1:0] aluop,
                                              input logic [5:0] funct);
        logic [3:0] code;
        code = c_alu_illegal;
        case (aluop)
            c_aluop_add: code = c_alu_add;
            c_aluop_sub: code = c_alu_sub;
            c_aluop_or:  code = c_alu_or;
            default: begin
                case (funct)
                    c_funct_add:   code = c_alu_add;
                    c_funct_sub:   code = c_alu_sub;
                    c_funct_and:   code = c_alu_and;
                    c_funct_or:    code = c_alu_or;
                    c_funct_xor:   code = c_alu_xor;
                    c_funct_nor:   code = c_alu_nor;
                    c_funct_slt:   code = c_alu_slt;
                    c_funct_sltu:  code = c_alu_sltu;
                    c_funct_multu: code = c_alu_multu;
                    default:       code = c_alu_illegal;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative unsigned shift-add multiplier, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 r_busy;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(WIDTH);
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end else begin
                // Product was presented for one cycle via done; go idle.
                r_busy <= 1'b0;
            end
        end
    end

    assign done    = r_busy && (r_cnt == '0);
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Decoded ALU with valid/ready handshake and sequential MULTU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  hi,
    output logic              zero,
    output logic [3:0]        alucont,
    output logic              illegal
);

    ctrl_state_t          r_state;
    logic                 r_run;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_hi;
    logic                 r_zero;
    logic [3:0]           r_alucont;
    logic                 r_illegal;

    logic [3:0]           w_alucont_raw;
    logic [3:0]           w_alucont;
    logic                 w_illegal;
    logic                 w_is_mul;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_product;
    logic [WIDTH-1:0]     w_alu_result;

    assign w_alucont_raw = alu_decode(aluop, funct);
    assign w_alucont     = ((MUL_EN == 0) && (w_alucont_raw == c_alu_multu))
                           ? c_alu_illegal : w_alucont_raw;
    assign w_illegal     = (w_alucont == c_alu_illegal);
    assign w_is_mul      = (w_alucont == c_alu_multu);

    // r_run keeps in_ready low until the first edge after reset is released.
    assign w_in_ready  = reset && r_run && (r_state == st_idle)
                         && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_mul_start = w_accept && w_is_mul;

    always_comb begin
        w_alu_result = '0;
        case (w_alucont)
            c_alu_add:  w_alu_result = a + b;
            c_alu_sub:  w_alu_result = a - b;
            c_alu_and:  w_alu_result = a & b;
            c_alu_or:   w_alu_result = a | b;
            c_alu_xor:  w_alu_result = a ^ b;
            c_alu_nor:  w_alu_result = ~(a | b);
            c_alu_slt:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_alu_sltu: w_alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
            default:    w_alu_result = '0;
        endcase
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(
                .WIDTH   (WIDTH)
            ) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (w_mul_start),
                .a       (a),
                .b       (b),
                .done    (w_mul_done),
                .product (w_product)
            );
        end else begin : g_no_mul
            assign w_mul_done = 1'b0;
            assign w_product  = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= st_idle;
            r_run       <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_zero      <= 1'b1;
            r_alucont   <= c_alu_and;
            r_illegal   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                st_idle: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state     <= st_mul;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_result;
                            r_hi        <= '0;
                            r_zero      <= (w_alu_result == '0);
                            r_alucont   <= w_alucont;
                            r_illegal   <= w_illegal;
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                st_mul: begin
                    if (w_mul_done) begin
                        r_state     <= st_done;
                        r_out_valid <= 1'b1;
                        r_result    <= w_product[WIDTH-1:0];
                        r_hi        <= w_product[2*WIDTH-1:WIDTH];
                        r_zero      <= (w_product[WIDTH-1:0] == '0);
                        r_alucont   <= c_alu_multu;
                        r_illegal   <= 1'b0;
                    end
                end
                st_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= st_idle;
                    end
                end
                default: r_state <= st_idle;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign hi        = r_hi;
    assign zero      = r_zero;
    assign alucont   = r_alucont;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire
